// File: rtl/plab1_imul_accum.sv
// -----------------------------------------------------------------------------
// plab1_imul_accum
//
// Dot-product reduction stage that sits behind the integer multiplier. It adds
// up each group of consecutive 32-bit products (modulo 2^NBITS) and emits one
// sum per group over a val/rdy interface.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - asynchronous, active-high reset
//   len      - products per group, sampled with a group's first product
//              (a value of 0 is treated as 1)
//   in_msg   - product from the multiplier
//   in_val   - in_msg is valid
//   in_rdy   - block accepts a product this cycle
//   out_msg  - accumulated group sum
//   out_val  - out_msg is valid
//   out_rdy  - downstream accepts out_msg
// -----------------------------------------------------------------------------
module plab1_imul_accum #(
    parameter int NBITS = 32,
    parameter int LBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LBITS-1:0] len,
    input  logic [NBITS-1:0] in_msg,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [NBITS-1:0] out_msg,
    output logic             out_val,
    input  logic             out_rdy
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

    state_e             state_q,   state_d;
    logic [LBITS:0]     count_q,   count_d;
    logic [NBITS-1:0]   acc_q,     acc_d;
    logic [LBITS-1:0]   len_q,     len_d;
    logic               in_rdy_q,  in_rdy_d;
    logic               out_val_q, out_val_d;

    logic [LBITS-1:0]   len_eff_s;
    logic [LBITS-1:0]   group_len_s;
    logic [LBITS:0]     count_inc_s;
    logic               last_s;

    // Effective group length: the live len input is only meaningful for the
    // first product of a group; afterwards the captured len_q governs.
    always_comb begin
        len_eff_s   = (len == {LBITS{1'b0}}) ? {{(LBITS-1){1'b0}}, 1'b1} : len;
        group_len_s = (count_q == {(LBITS+1){1'b0}}) ? len_eff_s : len_q;
        count_inc_s = count_q + {{LBITS{1'b0}}, 1'b1};
        last_s      = (count_inc_s == {1'b0, group_len_s});
    end

    // Next-state logic for the accept/hold FSM and its datapath.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        len_d     = len_q;
        in_rdy_d  = in_rdy_q;
        out_val_d = out_val_q;
        case (state_q)
            ST_ACC: begin
                if (in_val) begin
                    if (count_q == {(LBITS+1){1'b0}}) begin
                        len_d = len_eff_s;
                        acc_d = in_msg;
                    end else begin
                        acc_d = acc_q + in_msg;
                    end
                    if (last_s) begin
                        // Group complete: present the sum next cycle and stop
                        // accepting (no bypass while a result is pending).
                        state_d   = ST_OUT;
                        count_d   = {(LBITS+1){1'b0}};
                        in_rdy_d  = 1'b0;
                        out_val_d = 1'b1;
                    end else begin
                        count_d = count_inc_s;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_rdy) begin
                    // acc is left as-is; the next group's first product
                    // overwrites it.
                    state_d   = ST_ACC;
                    in_rdy_d  = 1'b1;
                    out_val_d = 1'b0;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d   = ST_ACC;
                count_d   = {(LBITS+1){1'b0}};
                in_rdy_d  = 1'b1;
                out_val_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial or pending sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ACC;
            count_q   <= {(LBITS+1){1'b0}};
            acc_q     <= {NBITS{1'b0}};
            len_q     <= {LBITS{1'b0}};
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            len_q     <= len_d;
            in_rdy_q  <= in_rdy_d;
            out_val_q <= out_val_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_val = out_val_q;
    assign out_msg = acc_q;

endmodule

// File: tb/tb_plab1_imul_accum.sv
// -----------------------------------------------------------------------------
// Directed testbench for plab1_imul_accum. Inputs change and outputs are
// sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_plab1_imul_accum;

    logic        clk;
    logic        reset;
    logic [7:0]  len;
    logic [31:0] in_msg;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] out_msg;
    logic        out_val;
    logic        out_rdy;

    int total;
    int bad;
    int cyc;

    plab1_imul_accum #(.NBITS(32), .LBITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .len     (len),
        .in_msg  (in_msg),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .out_msg (out_msg),
        .out_val (out_val),
        .out_rdy (out_rdy)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // free-running cycle counter used for the throughput bound
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Offer one product and hold it until accepted (bounded wait).
    task automatic push(input logic [31:0] p);
        int n;
        in_msg = p;
        in_val = 1'b1;
        n = 0;
        while (!in_rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_rdy) begin
            total++;
            bad++;
            $display("FAIL push_timeout: in_rdy=%0b required 1 for product %h", in_rdy, p);
        end
        @(posedge clk); #1;
        in_val = 1'b0;
    endtask

    // Wait for a result (bounded), compare it, then acknowledge it.
    task automatic pop(input logic [31:0] exp, input string nm);
        int n;
        n = 0;
        while (!out_val && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!out_val) begin
            bad++;
            $display("FAIL %s_timeout: out_val=%0b required 1", nm, out_val);
        end else if (out_msg !== exp) begin
            bad++;
            $display("FAIL %s: out_msg=%h required %h", nm, out_msg, exp);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_rdy: got %0b required 1", in_rdy);
        end
        total++;
        if (out_val !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_val: got %0b required 0", out_val);
        end
        total++;
        if (out_msg !== 32'h0) begin
            bad++;
            $display("FAIL reset_out_msg: got %h required 00000000", out_msg);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        len = 8'd3;
        push(32'd6);
        len = 8'd1;              // mid-group change must be ignored
        push(32'd20);
        push(32'd12);
        total++;
        if (out_val !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency: out_val=%0b required 1 one cycle after last transfer", out_val);
        end
        pop(32'd38, "basic_sum3");
        total++;
        if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
            bad++;
            $display("FAIL basic_return_acc: in_rdy=%0b out_val=%0b required 1 0", in_rdy, out_val);
        end
        len = 8'd2;
        push(32'd130);
        push(32'd56);
        pop(32'd186, "basic_sum2");
    endtask

    task automatic test_wrap();
        len = 8'd2;
        push(32'hF001_0000);
        push(32'h2000_0000);
        pop(32'h1001_0000, "wrap_a");
        push(32'hFFFF_FFFF);
        push(32'h0000_0001);
        pop(32'h0000_0000, "wrap_b");
    endtask

    task automatic test_degenerate();
        len = 8'd1;
        push(32'd7);
        total++;
        if (out_val !== 1'b1) begin
            bad++;
            $display("FAIL len1_latency_a: out_val=%0b required 1", out_val);
        end
        pop(32'd7, "len1_a");
        push(32'd9);
        total++;
        if (out_val !== 1'b1) begin
            bad++;
            $display("FAIL len1_latency_b: out_val=%0b required 1", out_val);
        end
        pop(32'd9, "len1_b");
        len = 8'd0;
        push(32'd5);
        total++;
        if (out_val !== 1'b1) begin
            bad++;
            $display("FAIL len0_latency: out_val=%0b required 1", out_val);
        end
        pop(32'd5, "len0");
    endtask

    task automatic test_backpressure();
        len = 8'd2;
        push(32'd3);
        push(32'd4);
        // next group's first product is offered during the stall
        in_msg = 32'd1;
        in_val = 1'b1;
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_val !== 1'b1 || out_msg !== 32'd7 || in_rdy !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d]: out_val=%0b out_msg=%h in_rdy=%0b required 1 00000007 0",
                         i, out_val, out_msg, in_rdy);
            end
            @(posedge clk); #1;
        end
        pop(32'd7, "stall_result");
        push(32'd1);
        push(32'd1);
        pop(32'd2, "after_stall");
    endtask

    task automatic test_reset_mid();
        len = 8'd4;
        push(32'd10);
        push(32'd20);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state: out_val=%0b in_rdy=%0b required 0 1", out_val, in_rdy);
        end
        len = 8'd2;
        push(32'd1);
        push(32'd2);
        pop(32'd3, "midreset_sum");
    endtask

    task automatic test_random();
        logic [31:0] prod [80];
        logic [31:0] expv [20];
        int start;
        for (int g = 0; g < 20; g++) begin
            expv[g] = 32'h0;
            for (int k = 0; k < 4; k++) begin
                prod[g*4+k] = $urandom;
                expv[g]     = expv[g] + prod[g*4+k];
            end
        end
        len = 8'd4;
        start = cyc;
        fork
            begin : producer
                for (int i = 0; i < 80; i++) begin
                    int d;
                    d = $urandom_range(0, 3);
                    in_val = 1'b0;
                    repeat (d) begin
                        @(posedge clk); #1;
                    end
                    push(prod[i]);
                end
            end
            begin : consumer
                for (int g = 0; g < 20; g++) begin
                    int d;
                    int n;
                    n = 0;
                    while (!out_val && n < 400) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    d = $urandom_range(0, 14);
                    repeat (d) begin
                        @(posedge clk); #1;
                    end
                    pop(expv[g], $sformatf("random_g%0d", g));
                end
            end
        join
        total++;
        if (cyc - start >= 5000) begin
            bad++;
            $display("FAIL random_budget: cycles=%0d required < 5000", cyc - start);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        len     = 8'd0;
        in_msg  = 32'h0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_degenerate();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
